// File: rtl/sn_stream_decoder.sv
// sn_stream_decoder
//   Decodes a serial stochastic bitstream into a 10-bit value by counting the
//   ones in a window of N = 2^(win_sel+3) accepted bits (win_sel 5..7 -> 256).
//   Unipolar: K ones -> K.  Bipolar: K ones -> 2K - N in two's complement.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, ACTIVE HIGH despite the name
//   sn_bit     stochastic input bit, qualified by sn_valid
//   sn_valid   sn_bit is meaningful this cycle
//   enable     1 = decode, 0 = idle and discard any partial window
//   win_sel    window length select, sampled at every window start
//   bipolar    result encoding, sampled at every window start
//   out_ready  downstream accepts out_data when out_valid = 1
//   clr_ovr    synchronous clear of the sticky overrun flag
//   out_data   decoded result, held while out_valid = 1 and out_ready = 0
//   out_valid  out_data holds a result not yet accepted
//   overrun    sticky: a completed window was dropped
//
// Handshake: a result transfers on any rising edge where out_valid = 1 and
// out_ready = 1. out_data is stable while out_valid = 1 and out_ready = 0.
// A window that completes while a result is stalled is dropped and flags
// overrun; one that completes on the transfer edge replaces the old result.

module sn_stream_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sn_bit,
    input  logic       sn_valid,
    input  logic       enable,
    input  logic [2:0] win_sel,
    input  logic       bipolar,
    input  logic       out_ready,
    input  logic       clr_ovr,
    output logic [9:0] out_data,
    output logic       out_valid,
    output logic       overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state_q,    state_d;
    logic [8:0] bit_cnt_q,  bit_cnt_d;
    logic [8:0] ones_cnt_q, ones_cnt_d;
    logic [2:0] sel_q,      sel_d;
    logic       bip_q,      bip_d;
    logic [9:0] data_q,     data_d;
    logic       valid_q,    valid_d;
    logic       ovr_q,      ovr_d;

    logic [8:0] win_last;
    logic [9:0] win_n;
    logic       accept;
    logic       done;
    logic [8:0] ones_next;
    logic [9:0] result;
    logic       drop;

    // Index of the last bit in the window (N-1) for the latched selection.
    always_comb begin
        case (sel_q)
            3'd0:    win_last = 9'd7;
            3'd1:    win_last = 9'd15;
            3'd2:    win_last = 9'd31;
            3'd3:    win_last = 9'd63;
            3'd4:    win_last = 9'd127;
            default: win_last = 9'd255;
        endcase
    end

    assign win_n     = {1'b0, win_last} + 10'd1;
    assign accept    = (state_q == ST_RUN) && enable && sn_valid;
    assign done      = accept && (bit_cnt_q == win_last);
    assign ones_next = ones_cnt_q + {8'd0, sn_bit};
    // 2K - N evaluated modulo 1024 gives the correct 10-bit two's complement,
    // including the +256 corner where 2K itself needs 10 bits.
    assign result    = bip_q ? ({ones_next, 1'b0} - win_n) : {1'b0, ones_next};
    assign drop      = done && valid_q && !out_ready;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        sel_d      = sel_q;
        bip_d      = bip_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    sel_d      = win_sel;
                    bip_d      = bipolar;
                    bit_cnt_d  = 9'd0;
                    ones_cnt_d = 9'd0;
                end
            end
            default: begin
                if (!enable) begin
                    // Partial window is discarded; pending output is untouched.
                    state_d    = ST_IDLE;
                    bit_cnt_d  = 9'd0;
                    ones_cnt_d = 9'd0;
                end else if (done) begin
                    // Next window starts immediately with fresh configuration.
                    bit_cnt_d  = 9'd0;
                    ones_cnt_d = 9'd0;
                    sel_d      = win_sel;
                    bip_d      = bipolar;
                end else if (accept) begin
                    bit_cnt_d  = bit_cnt_q + 9'd1;
                    ones_cnt_d = ones_next;
                end
            end
        endcase

        if (done && !drop) begin
            data_d  = result;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as clr_ovr keeps the flag set.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 9'd0;
            ones_cnt_q <= 9'd0;
            sel_q      <= 3'd0;
            bip_q      <= 1'b0;
            data_q     <= 10'd0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            sel_q      <= sel_d;
            bip_q      <= bip_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_sn_stream_decoder.sv
// tb_sn_stream_decoder
//   Directed scenarios for the decoder's key behaviours followed by a long
//   randomized run. A window-level reference model (bit/ones tallies, latched
//   window length, pending result slot) predicts the outputs every cycle.
//   Inputs change 1 ns after the rising edge; outputs are checked 1 ns after.

module tb_sn_stream_decoder;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sn_bit, sn_valid, enable, bipolar, out_ready, clr_ovr;
    logic [2:0] win_sel;
    logic [9:0] out_data;
    logic       out_valid, overrun;

    always #5 clk = ~clk;

    sn_stream_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sn_bit    (sn_bit),
        .sn_valid  (sn_valid),
        .enable    (enable),
        .win_sel   (win_sel),
        .bipolar   (bipolar),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_run;
    int m_cnt, m_ones, m_n;
    bit m_bip;
    bit m_valid;
    bit [9:0] m_data;
    bit m_ovr;

    function automatic int n_of(input int sel);
        return (sel >= 5) ? 256 : (8 << sel);
    endfunction

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_ones = 0; m_n = 8; m_bip = 0;
        m_valid = 0; m_data = '0; m_ovr = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs held before it.
    task automatic model_edge();
        bit done;
        int res;
        bit drop;
        done = 0;
        res  = 0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1; m_cnt = 0; m_ones = 0;
                m_n = n_of(int'(win_sel)); m_bip = bipolar;
            end
        end else if (!enable) begin
            m_run = 0; m_cnt = 0; m_ones = 0;
        end else if (sn_valid) begin
            m_cnt++;
            m_ones += int'(sn_bit);
            if (m_cnt == m_n) begin
                done = 1;
                res  = m_bip ? (2 * m_ones - m_n) : m_ones;
                m_cnt = 0; m_ones = 0;
                m_n = n_of(int'(win_sel)); m_bip = bipolar;
            end
        end
        drop = done && m_valid && !out_ready;
        if (done && !drop) begin
            m_valid = 1;
            m_data  = res[9:0];
            exp_q.push_back(res[9:0]);
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        if (!rst_n && out_valid && out_ready) begin
            if (exp_q.size() > 0) check("accepted_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
            else                  check("unexpected_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        if (rst_n) model_reset();
        else       model_edge();
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
        check("out_data",  {22'd0, out_data},  {22'd0, m_data});
    endtask

    task automatic cyc(input logic en, input logic v, input logic b, input logic r);
        enable = en; sn_valid = v; sn_bit = b; out_ready = r;
        step();
    endtask

    task automatic restart(input logic [2:0] sel, input logic bip, input logic r);
        cyc(1'b0, 1'b0, 1'b0, r);
        win_sel = sel; bipolar = bip;
        cyc(1'b1, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        rst_n = 1'b1; sn_bit = 0; sn_valid = 0; enable = 0; win_sel = 0;
        bipolar = 0; out_ready = 0; clr_ovr = 0;
        model_reset();
        do_reset();
        check("reset_data",  {22'd0, out_data}, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);

        // Unipolar 8-bit window 1,1,0,1,0,0,1,1 -> 5, valid for one cycle.
        restart(3'd0, 1'b0, 1'b1);
        pat = 8'b1101_0011;
        for (int i = 0; i < 8; i++) cyc(1, 1, pat[7-i], 1);
        check("uni8_valid", {31'd0, out_valid}, 32'd1);
        check("uni8_data",  {22'd0, out_data}, 32'd5);
        cyc(1, 0, 0, 1);
        check("uni8_pulse", {31'd0, out_valid}, 32'd0);

        // Bipolar 16-bit windows back to back.
        restart(3'd1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1);
        check("bip_all0", {22'd0, out_data}, 32'h3F0);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1, 1);
        check("bip_all1", {22'd0, out_data}, 32'd16);
        for (int i = 0; i < 16; i++) cyc(1, 1, (i < 12) ? 1'b1 : 1'b0, 1);
        check("bip_12", {22'd0, out_data}, 32'd8);

        // 256-bit window, sn_valid every other cycle.
        restart(3'd7, 1'b0, 1'b1);
        for (int i = 0; i < 511; i++) cyc(1, (i % 2 == 0) ? 1'b1 : 1'b0, 1, 1);
        check("w256_valid", {31'd0, out_valid}, 32'd1);
        check("w256_data",  {22'd0, out_data}, 32'd256);
        cyc(1, 0, 0, 1);

        // Stall across two windows -> overrun, old result held.
        restart(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0);
        check("stall_first", {22'd0, out_data}, 32'd8);
        for (int i = 0; i < 8; i++) cyc(1, 1, (i < 3) ? 1'b1 : 1'b0, 0);
        check("stall_ovr",  {31'd0, overrun}, 32'd1);
        check("stall_hold", {22'd0, out_data}, 32'd8);
        clr_ovr = 1'b1;
        cyc(1, 0, 0, 0);
        clr_ovr = 1'b0;
        check("clr_ovr", {31'd0, overrun}, 32'd0);
        cyc(1, 0, 0, 1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Enable dropped mid-window, then a full window; mid-window win_sel change.
        restart(3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check("partial_none", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) cyc(1, 1, i[0], 1);
        check("after_partial", {22'd0, out_data}, 32'd4);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1);
        win_sel = 3'd1;
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1);
        check("midsel_old_n", {22'd0, out_data}, 32'd8);
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 1);
        check("midsel_new_wait", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 1);
        check("midsel_new_n", {22'd0, out_data}, 32'd16);

        // Asynchronous reset with a pending result and 3 bits counted.
        restart(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1, 1, 1, 0);
        #2 rst_n = 1'b1;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_data",  {22'd0, out_data}, 32'd0);
        check("async_ovr",   {31'd0, overrun}, 32'd0);
        step();
        rst_n = 1'b0;
        restart(3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 1);
        check("post_reset", {22'd0, out_data}, 32'd8);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                win_sel = 3'($urandom_range(0, 2));
                bipolar = 1'($urandom_range(0, 1));
            end
            clr_ovr = ($urandom_range(0, 15) == 0);
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end
        clr_ovr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sn_stream_decoder.md
SN_STREAM_DECODER -- requirements
Module: sn_stream_decoder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-high reset (asserted = 1, despite the name).
REQ-003 SHALL have port: sn_bit  input  1  serial stochastic bit from the upstream multiplier stage.
REQ-004 SHALL have port: sn_valid  input  1  sn_bit is qualified this cycle.
REQ-005 SHALL have port: enable  input  1  1 = decode, 0 = idle and discard any partial window.
REQ-006 SHALL have port: win_sel  input  3  window length N = 2^(win_sel+3); values 6 and 7 map to N = 256.
REQ-007 SHALL have port: bipolar  input  1  0 = unipolar result, 1 = bipolar result.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-009 SHALL have port: clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-010 SHALL have port: out_data  output  10  result; two's complement in bipolar mode.
REQ-011 SHALL have port: out_valid  output  1  out_data holds an unaccepted result.
REQ-012 SHALL have port: overrun  output  1  sticky; at least one completed window was dropped.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE -> RUN when enable = 1; RUN -> IDLE when enable = 0.
REQ-014 SHALL, on entering RUN and at every window start, latch win_sel and bipolar; changes mid-window SHALL take effect from the next window only.
REQ-015 SHALL, in RUN, count accepted bits (sn_valid = 1) in a 9-bit bit counter and accepted ones (sn_valid = 1 and sn_bit = 1) in a 9-bit ones counter.
REQ-016 SHALL ignore sn_bit on cycles with sn_valid = 0; no counter advances.
REQ-017 SHALL complete a window on the cycle the N-th bit is accepted, with that bit included in the count.
REQ-018 SHALL compute the result from ones count K: unipolar = K zero-extended to 10 bits (range 0..256); bipolar = 2K - N as signed 10-bit (range -256..+256).
REQ-019 SHALL present the result on out_data with out_valid = 1 on the cycle after window completion (latency 1).
REQ-020 SHALL restart the window on the cycle after completion with both counters at 0 plus the bit accepted that cycle; there SHALL be no dead cycles between windows.
REQ-021 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL clear out_valid on the cycle after out_valid = 1 and out_ready = 1, unless a new result loads on that same edge.
REQ-023 SHALL, when a window completes while out_valid = 1 and out_ready = 0, keep the old result, drop the new one, and set overrun.
REQ-024 SHALL, when a window completes in the same cycle as out_valid = 1 and out_ready = 1, load the new result, keep out_valid = 1, and leave overrun unchanged.
REQ-025 SHALL clear overrun on the edge after clr_ovr = 1; if a drop occurs in that same cycle, set SHALL win and overrun stays 1.
REQ-026 SHALL, when enable falls mid-window, clear both counters, produce no result, and leave any pending out_valid/out_data untouched.
REQ-027 SHALL not wrap the counters; the bit counter is compared against N-1 each cycle and N <= 256 fits in 9 bits.

Reset
REQ-028 SHALL, while rst_n = 1, immediately force: FSM = IDLE, both counters = 0, out_data = 0, out_valid = 0, overrun = 0, latched win_sel = 0, latched bipolar = 0.
REQ-029 SHALL, when reset asserts mid-window or with a result pending, lose the partial window and the pending result without a handshake.
REQ-030 SHALL resume normal operation on the first rising edge of clk after rst_n deasserts.

Verification
REQ-031 SHALL pass: win_sel = 0, unipolar, 8 valid bits 1,1,0,1,0,0,1,1, out_ready = 1 -> out_data = 5, out_valid for 1 cycle, 1 cycle after the 8th bit.
REQ-032 SHALL pass: win_sel = 1, bipolar, 16 bits all 0 -> out_data = -16 (0x3F0); 16 bits all 1 -> +16; 12 ones -> +8.
REQ-033 SHALL pass: win_sel = 7, unipolar, 256 bits all 1 with sn_valid toggling every other cycle -> out_data = 256 after the 256th valid bit only.
REQ-034 SHALL pass: win_sel = 0, out_ready = 0 across two windows -> first result held, overrun = 1; clr_ovr pulse -> overrun = 0; out_ready then -> out_valid clears.
REQ-035 SHALL pass: enable dropped after 5 of 8 bits, then raised -> no output for the partial window; next full 8-bit window decodes correctly; changing win_sel mid-window -> the current window keeps its old N.
REQ-036 SHALL pass: rst_n asserted with out_valid = 1 and 3 bits counted -> all outputs 0 asynchronously, before the next clk edge.
